// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the L1 miss-path memory request arbiter.
// Requester IDs, issue FSM state encoding, default geometry and the
// line-alignment mask used on outgoing request addresses.
// Build option: MEM_ARB_IC_PRIORITY_EN (fixed Icache priority in ARB).
package mem_arb_pkg;

    // Default geometry of the memory line-request port
    localparam int unsigned DEF_ADDR_WIDTH      = 64;
    localparam int unsigned DEF_LINE_SIZE       = 512;
    localparam int unsigned DEF_OFFSET_WIDTH    = 6;
    localparam int unsigned DEF_MAX_OUTSTANDING = 4;
    localparam int unsigned DEF_PTR_WIDTH       = 2;

    // Requester identifiers stored in the in-order ID FIFO
    localparam logic SRC_IC = 1'b0;
    localparam logic SRC_DC = 1'b1;

    // Issue FSM: free arbitration, or a grant locked until memory accepts it
    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // Clears the line-offset bits of an address for the default geometry
    localparam logic [DEF_ADDR_WIDTH-1:0] LINE_ALIGN_MASK =
        {DEF_ADDR_WIDTH{1'b1}} << DEF_OFFSET_WIDTH;

    // Builds the alignment mask for an arbitrary offset width (64-bit addresses)
    function automatic logic [DEF_ADDR_WIDTH-1:0] line_align_mask(input int unsigned offset_width);
        line_align_mask = {DEF_ADDR_WIDTH{1'b1}} << offset_width;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_id_fifo.sv
// In-order requester ID FIFO, one bit wide.
// Records which cache issued each outstanding memory request so that
// refills can be routed back in issue order. Head is read combinationally
// so routing has zero latency. Pointers wrap naturally (power-of-2 depth).
// Build option: none (MEM_ARB_IC_PRIORITY_EN only affects the top).
module id_fifo #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PTR_WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic               i_din,
    input  logic               i_pop,
    output logic               o_dout,
    output logic               o_empty,
    output logic [PTR_WIDTH:0] o_count
);

    localparam logic [PTR_WIDTH:0] L_DEPTH = (PTR_WIDTH+1)'(DEPTH);

    logic                 r_mem [DEPTH];
    logic [PTR_WIDTH-1:0] r_wr_ptr;
    logic [PTR_WIDTH-1:0] r_rd_ptr;
    logic [PTR_WIDTH:0]   r_count;

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == L_DEPTH);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage write; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop keep the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Memory line-request arbiter between the Icache and Dcache miss paths.
// Issues one request at a time to memory (round-robin, or fixed Icache
// priority when MEM_ARB_IC_PRIORITY_EN is defined), locks a grant that
// memory has not yet accepted, and routes refills back in issue order via
// an ID FIFO. Request-side handshakes are combinational so an accepting
// memory sees back-to-back grants.
// Build option: MEM_ARB_IC_PRIORITY_EN.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int unsigned LINE_SIZE       = DEF_LINE_SIZE,
    parameter int unsigned OFFSET_WIDTH    = DEF_OFFSET_WIDTH,
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int unsigned PTR_WIDTH       = DEF_PTR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ic_req_valid_i,
    output logic                  ic_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr_i,
    input  logic                  dc_req_valid_i,
    output logic                  dc_req_ready_o,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                  mem_resp_valid_i,
    output logic                  mem_resp_ready_o,
    input  logic [LINE_SIZE-1:0]  mem_resp_data_i,
    output logic                  ic_refill_valid_o,
    input  logic                  ic_refill_ready_i,
    output logic [LINE_SIZE-1:0]  ic_refill_data_o,
    output logic                  dc_refill_valid_o,
    input  logic                  dc_refill_ready_i,
    output logic [LINE_SIZE-1:0]  dc_refill_data_o
);

    localparam logic [ADDR_WIDTH-1:0] L_ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_WIDTH;
    localparam logic [PTR_WIDTH:0]    L_MAX_OUT    = (PTR_WIDTH+1)'(MAX_OUTSTANDING);

    // Issue state
    arb_state_t r_state;
    logic       r_lock;
    logic       r_last;

    // Issue datapath
    logic       w_full;
    logic       w_winner;
    logic       w_sel;
    logic       w_issue_valid;
    logic       w_push;

    // ID FIFO interface
    logic               w_head;
    logic               w_empty;
    logic               w_pop;
    logic [PTR_WIDTH:0] w_count;

    // Full is judged on the registered count; a same-cycle pop does not help
    assign w_full = (w_count == L_MAX_OUT);

    // Winner selection when both requesters compete in ARB
`ifdef MEM_ARB_IC_PRIORITY_EN
    assign w_winner = ic_req_valid_i ? SRC_IC : SRC_DC;
`else
    assign w_winner = (ic_req_valid_i && dc_req_valid_i) ? ~r_last :
                      (ic_req_valid_i ? SRC_IC : SRC_DC);
`endif

    // Request-side handshake: who is offered to memory and who gets ready
    always_comb begin
        w_sel          = SRC_IC;
        w_issue_valid  = 1'b0;
        w_push         = 1'b0;
        ic_req_ready_o = 1'b0;
        dc_req_ready_o = 1'b0;
        case (r_state)
            ARB: begin
                if (!w_full && (ic_req_valid_i || dc_req_valid_i)) begin
                    w_issue_valid = 1'b1;
                    w_sel         = w_winner;
                end
            end
            HOLD: begin
                w_sel         = r_lock;
                w_issue_valid = (r_lock == SRC_DC) ? dc_req_valid_i : ic_req_valid_i;
            end
            default: begin
                w_issue_valid = 1'b0;
            end
        endcase
        // Nothing is offered while reset is asserted
        w_issue_valid = w_issue_valid && rst_n;
        if (w_issue_valid && mem_req_ready_i) begin
            w_push = 1'b1;
            if (w_sel == SRC_DC) begin
                dc_req_ready_o = 1'b1;
            end else begin
                ic_req_ready_o = 1'b1;
            end
        end
    end

    assign mem_req_valid_o = w_issue_valid;
    assign mem_req_addr_o  = ((w_sel == SRC_DC) ? dc_req_addr_i : ic_req_addr_i) & L_ALIGN_MASK;

    // Issue FSM: lock an unaccepted grant, release it on accept or requester drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB;
            r_lock  <= SRC_IC;
            r_last  <= SRC_DC;
        end else begin
            case (r_state)
                ARB: begin
                    if (w_issue_valid) begin
                        if (mem_req_ready_i) begin
                            r_last <= w_sel;
                        end else begin
                            r_lock  <= w_sel;
                            r_state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!w_issue_valid) begin
                        r_state <= ARB;
                    end else if (mem_req_ready_i) begin
                        r_last  <= w_sel;
                        r_state <= ARB;
                    end
                end
                default: begin
                    r_state <= ARB;
                end
            endcase
        end
    end

    // Refill routing: head ID picks the destination, data goes to both
    assign ic_refill_valid_o = mem_resp_valid_i && !w_empty && (w_head == SRC_IC);
    assign dc_refill_valid_o = mem_resp_valid_i && !w_empty && (w_head == SRC_DC);
    assign mem_resp_ready_o  = !w_empty && ((w_head == SRC_DC) ? dc_refill_ready_i : ic_refill_ready_i);
    assign w_pop             = mem_resp_valid_i && mem_resp_ready_o;
    assign ic_refill_data_o  = mem_resp_data_i;
    assign dc_refill_data_o  = mem_resp_data_i;

    id_fifo #(
        .DEPTH     (MAX_OUTSTANDING),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_id_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_sel),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the single memory-subsystem line-request port between the Icache miss path and the Dcache miss path.
- Arbitrates requests round-robin and records the source of each issued request in an in-order ID FIFO.
- Routes each 512-bit refill response back to the requester that issued it.
- Sits between both L1 caches and the memory subsystem; it is the only owner of the memory request/response handshakes.

Parameters:
- ADDR_WIDTH, 64, request address width.
- LINE_SIZE, 512, refill data width in bits.
- OFFSET_WIDTH, 6, line offset bits cleared on the outgoing address.
- MAX_OUTSTANDING, 4, maximum issued-but-unanswered requests (ID FIFO depth, power of 2).
- PTR_WIDTH, 2, log2(MAX_OUTSTANDING).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ic_req_valid_i  in  1  Icache miss request
- ic_req_ready_o  out  1  Icache request accepted
- ic_req_addr_i  in  ADDR_WIDTH  Icache miss address (unaligned pc allowed)
- dc_req_valid_i  in  1  Dcache miss request
- dc_req_ready_o  out  1  Dcache request accepted
- dc_req_addr_i  in  ADDR_WIDTH  Dcache miss address
- mem_req_valid_o  out  1  request to memory
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  ADDR_WIDTH  line-aligned address
- mem_resp_valid_i  in  1  memory refill valid
- mem_resp_ready_o  out  1  refill consumed
- mem_resp_data_i  in  LINE_SIZE  refill line
- ic_refill_valid_o  out  1  refill to Icache
- ic_refill_ready_i  in  1  Icache accepts refill
- ic_refill_data_o  out  LINE_SIZE  refill line to Icache
- dc_refill_valid_o  out  1  refill to Dcache
- dc_refill_ready_i  in  1  Dcache accepts refill
- dc_refill_data_o  out  LINE_SIZE  refill line to Dcache

Behaviour:
- Reset: rst_n asynchronous, active-low, clock clk. At reset, grant lock, last-winner pointer (points at Dcache so Icache wins first), FIFO pointers and outstanding count are all cleared. All valid/ready outputs are 0 during and after reset until inputs drive them. Reset mid-operation discards all outstanding IDs; the memory subsystem is reset in the same domain.
- Issue FSM (2 states):
  - ARB:
    - If count < MAX_OUTSTANDING and any requester is valid, pick the winner round-robin. On a tie, the requester that is not the last winner wins.
    - Drive mem_req_valid_o=1 with the winner's address, bits [OFFSET_WIDTH-1:0] forced to 0.
    - If mem_req_ready_i=1 in the same cycle: winner ready=1, push winner ID (0=Ic, 1=Dc), update the last winner, stay in ARB.
    - Otherwise latch the winner into the grant lock and go to HOLD.
  - HOLD:
    - Keep mem_req_valid_o=1 for the locked requester. The other requester's ready stays 0 and it cannot preempt.
    - When mem_req_ready_i=1: locked requester ready=1, push ID, go to ARB.
    - If the locked requester drops valid (protocol violation), go to ARB without issuing.
- Full: count==MAX_OUTSTANDING means no new grant, mem_req_valid_o=0, both ready=0. A same-cycle response pop does not enable a push; the full decision uses the registered count.
- Response routing (combinational, zero latency):
  - Head ID selects the destination. That destination's refill_valid = mem_resp_valid_i && !empty; the data is passed through on both data outputs.
  - mem_resp_ready_o = !empty && ready of the destination.
  - A pop occurs on mem_resp_valid_i && mem_resp_ready_o.
  - Empty FIFO: mem_resp_ready_o=0, both refill valids are 0.
- Count: +1 on push only, -1 on pop only, unchanged when push and pop occur in the same cycle. Pointers wrap modulo MAX_OUTSTANDING.

Optional Feature:
- MEM_ARB_IC_PRIORITY_EN defined: fixed priority replaces round-robin in ARB. Icache always wins when valid. The Dcache is granted only when ic_req_valid_i=0. The HOLD lock is still honoured.
- Undefined: round-robin as above.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the requester ID constants SRC_IC=1'b0 and SRC_DC=1'b1;
  - the state encodings ARB=1'b0 and HOLD=1'b1;
  - the line-alignment mask helper constant derived from OFFSET_WIDTH.
- One natural sub-module: id_fifo (1-bit wide, MAX_OUTSTANDING deep; push/pop/full/empty/count).

Test Plan:
- Both valid every cycle, mem_req_ready_i=1, responses returned in order → grants alternate Ic,Dc,Ic,Dc; refills land at Ic,Dc,Ic,Dc.
- ic_req_addr_i=0x1234 → mem_req_addr_o=0x1200. With mem_req_ready_i held 0 for 3 cycles while Dc is valid → address stable, dc_req_ready_o=0 throughout, Ic accepted on cycle 4.
- Issue 4 requests with no responses → 5th request sees mem_req_valid_o=0. A response then pops → the 5th is granted the next cycle, not in the pop cycle.
- Response for an Ic head with ic_refill_ready_i=0 for 2 cycles → mem_resp_ready_o=0, ic_refill_valid_o=1 held, no pop; pop occurs on the 3rd cycle.
- Push and pop in the same cycle at count=2 → count stays 2. Assert rst_n low mid-burst → count 0, all valid/ready outputs 0.
- With MEM_ARB_IC_PRIORITY_EN, both valid for 3 cycles → Ic granted all 3, Dc granted when Ic drops.
